// File: rtl/sha3_msg_sequencer_pkg.sv
// Shared types and constants for the SHA3-256 message sequencer.
// Holds the FSM state encoding, rate-block geometry and padding byte values.
package sha3_seq_pkg;

   typedef enum logic [2:0] {
      FILL,
      PAD,
      ISSUE,
      WAIT_NEXT,
      WAIT_DGST,
      OUT
   } seq_state_t;

   localparam int        RATE_BYTES = 136;
   localparam int        WPB        = 17;
   localparam logic [7:0] PAD_FIRST = 8'h06;
   localparam logic [7:0] PAD_LAST  = 8'h80;

   // A final word can never carry more than a full word of message bytes.
   function automatic logic [3:0] clamp_bytes(input logic [3:0] b);
      return (b > 4'd8) ? 4'd8 : b;
   endfunction

endpackage

// File: rtl/sha3_msg_sequencer_if.sv
// Word-in / block-out / digest-out bus bundle for sha3_msg_sequencer.
// slave = sequencer side, master = system side (word source, SHA3 core, digest sink).
interface sha3_msg_sequencer_if #(
   parameter int WORD_W   = 64,
   parameter int RATE_W   = 1088,
   parameter int DIGEST_W = 256
);
   logic                s_valid;
   logic                s_ready;
   logic [WORD_W-1:0]   s_data;
   logic                s_last;
   logic [3:0]          s_bytes;
   logic [RATE_W-1:0]   core_in;
   logic                core_in_valid;
   logic                core_more;
   logic                core_hash_next;
   logic [DIGEST_W-1:0] core_out;
   logic                core_out_valid;
   logic                m_valid;
   logic                m_ready;
   logic [DIGEST_W-1:0] m_digest;
   logic                busy;

   modport slave (
      input  s_valid, s_data, s_last, s_bytes,
      input  core_hash_next, core_out, core_out_valid,
      input  m_ready,
      output s_ready, core_in, core_in_valid, core_more,
      output m_valid, m_digest, busy
   );

   modport master (
      output s_valid, s_data, s_last, s_bytes,
      output core_hash_next, core_out, core_out_valid,
      output m_ready,
      input  s_ready, core_in, core_in_valid, core_more,
      input  m_valid, m_digest, busy
   );
endinterface

// File: rtl/sha3_msg_sequencer_pad.sv
// Combinational SHA3 pad10*1 on one rate block: keeps bytes below p, writes 0x06 at p, zeroes the rest, ORs 0x80 into the last byte.
// p >= block size passes the block through untouched (message ended exactly on the boundary).
module sha3_pad_unit
   import sha3_seq_pkg::*;
#(
   parameter int RATE_W = 1088
) (
   input  logic [RATE_W-1:0] i_blk,
   input  logic [7:0]        i_p,
   output logic [RATE_W-1:0] o_blk
);
   localparam int NB = RATE_W / 8;

   always_comb begin
      o_blk = '0;
      for (int b = 0; b < NB; b++) begin
         if (8'(b) < i_p)
            o_blk[RATE_W-1-8*b -: 8] = i_blk[RATE_W-1-8*b -: 8];
         else if (8'(b) == i_p)
            o_blk[RATE_W-1-8*b -: 8] = PAD_FIRST;
         else
            o_blk[RATE_W-1-8*b -: 8] = 8'h00;
      end
      if (i_p < 8'(NB))
         o_blk[7:0] = o_blk[7:0] | PAD_LAST;
   end
endmodule

// File: rtl/sha3_msg_sequencer.sv
// Packs 64-bit message words into padded 1088-bit blocks for SHA3TOP and returns the digest; s_last accept -> core_in_valid in 2 cycles,
// core_out_valid -> m_valid in 1 cycle; s_ready only in FILL. SHA3_SEQ_STATS_EN adds blk_count/msg_count outputs.
module sha3_msg_sequencer
   import sha3_seq_pkg::*;
#(
   parameter int WORD_W   = 64,
   parameter int RATE_W   = 1088,
   parameter int DIGEST_W = 256
) (
   input  logic               clk,
   input  logic               rst,
   sha3_msg_sequencer_if.slave io_bus
`ifdef SHA3_SEQ_STATS_EN
   ,
   output logic [15:0]        blk_count,
   output logic [15:0]        msg_count
`endif
);
   seq_state_t          r_state;
   logic [4:0]          r_k;
   logic [7:0]          r_p;
   logic [RATE_W-1:0]   r_buf;
   logic [RATE_W-1:0]   r_core_in;
   logic                r_core_in_valid;
   logic                r_core_more;
   logic                r_pad_pending;
   logic                r_m_valid;
   logic [DIGEST_W-1:0] r_digest;

   logic                w_accept;
   logic [7:0]          w_p_last;
   logic [7:0]          w_pad_p;
   logic [RATE_W-1:0]   w_buf_next;
   logic [RATE_W-1:0]   w_padded;

   assign io_bus.s_ready       = (r_state == FILL) && !rst;
   assign io_bus.core_in       = r_core_in;
   assign io_bus.core_in_valid = r_core_in_valid;
   assign io_bus.core_more     = r_core_more;
   assign io_bus.m_valid       = r_m_valid;
   assign io_bus.m_digest      = r_digest;
   assign io_bus.busy          = !((r_state == FILL) && (r_k == 5'd0));

   assign w_accept = io_bus.s_valid && io_bus.s_ready;
   assign w_p_last = {r_k, 3'b000} + {4'd0, clamp_bytes(io_bus.s_bytes)};
   // The trailing all-pad block is built from an offset of zero, so stale buffer bytes never leak into it.
   assign w_pad_p  = (r_state == WAIT_NEXT) ? 8'd0 : r_p;

   always_comb begin
      w_buf_next = r_buf;
      for (int i = 0; i < WPB; i++) begin
         if (w_accept && (r_k == 5'(i)))
            w_buf_next[RATE_W-1-WORD_W*i -: WORD_W] = io_bus.s_data;
      end
   end

   sha3_pad_unit #(.RATE_W(RATE_W)) u_pad (
      .i_blk (r_buf),
      .i_p   (w_pad_p),
      .o_blk (w_padded)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= FILL;
         r_k             <= 5'd0;
         r_p             <= 8'd0;
         r_buf           <= '0;
         r_core_in       <= '0;
         r_core_in_valid <= 1'b0;
         r_core_more     <= 1'b0;
         r_pad_pending   <= 1'b0;
         r_m_valid       <= 1'b0;
         r_digest        <= '0;
      end else begin
         r_buf <= w_buf_next;
         case (r_state)
            FILL: begin
               if (w_accept) begin
                  if (io_bus.s_last) begin
                     r_p     <= w_p_last;
                     r_state <= PAD;
                  end else if (r_k == 5'(WPB - 1)) begin
                     r_k             <= 5'd0;
                     r_core_in       <= w_buf_next;
                     r_core_in_valid <= 1'b1;
                     r_core_more     <= 1'b1;
                     r_state         <= ISSUE;
                  end else begin
                     r_k <= r_k + 5'd1;
                  end
               end
            end
            PAD: begin
               r_core_in       <= w_padded;
               r_core_in_valid <= 1'b1;
               r_core_more     <= (r_p == 8'(RATE_BYTES));
               r_pad_pending   <= (r_p == 8'(RATE_BYTES));
               r_k             <= 5'd0;
               r_state         <= ISSUE;
            end
            ISSUE: begin
               r_core_in_valid <= 1'b0;
               r_state         <= r_core_more ? WAIT_NEXT : WAIT_DGST;
            end
            WAIT_NEXT: begin
               if (io_bus.core_hash_next) begin
                  if (r_pad_pending) begin
                     r_core_in       <= w_padded;
                     r_core_in_valid <= 1'b1;
                     r_core_more     <= 1'b0;
                     r_pad_pending   <= 1'b0;
                     r_state         <= ISSUE;
                  end else begin
                     r_state <= FILL;
                  end
               end
            end
            WAIT_DGST: begin
               if (io_bus.core_out_valid) begin
                  r_digest  <= io_bus.core_out;
                  r_m_valid <= 1'b1;
                  r_state   <= OUT;
               end
            end
            OUT: begin
               if (io_bus.m_ready) begin
                  r_m_valid <= 1'b0;
                  r_k       <= 5'd0;
                  r_state   <= FILL;
               end
            end
            default: r_state <= FILL;
         endcase
      end
   end

`ifdef SHA3_SEQ_STATS_EN
   logic [15:0] r_blk_count;
   logic [15:0] r_msg_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_blk_count <= 16'd0;
         r_msg_count <= 16'd0;
      end else begin
         if ((r_state == ISSUE) && (r_blk_count != 16'hFFFF))
            r_blk_count <= r_blk_count + 16'd1;
         if (r_m_valid && io_bus.m_ready)
            r_msg_count <= r_msg_count + 16'd1;
      end
   end

   assign blk_count = r_blk_count;
   assign msg_count = r_msg_count;
`endif
endmodule

// File: tb/tb_sha3_msg_sequencer.sv
// Bench for sha3_msg_sequencer: random messages checked against a byte-level pad10*1 model, with a behavioural SHA3 core responder.
module tb_sha3_msg_sequencer;
   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;

   sha3_msg_sequencer_if bus ();

`ifdef SHA3_SEQ_STATS_EN
   logic [15:0] blk_count;
   logic [15:0] msg_count;
`endif

   sha3_msg_sequencer dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus)
`ifdef SHA3_SEQ_STATS_EN
      ,
      .blk_count (blk_count),
      .msg_count (msg_count)
`endif
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   // Responder state: blocks seen by the core and its reply pacing.
   logic [1087:0] got_blk[$];
   logic          got_more[$];
   int            got_cyc[$];
   int            sready_bad;
   int            ov_cyc;
   logic [255:0]  exp_dig;
   bit            hold_next;
   int            rsp_mode;
   int            rsp_cnt;
   int            blk_since;
   int            msgs_since;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_blk(input string tag, input logic [1087:0] obs, input logic [1087:0] exp);
      int fb;
      logic [1087:0] ts, te;
      fb = -1;
      for (int b = 0; b < 136; b++) begin
         ts = obs >> (1080 - 8*b);
         te = exp >> (1080 - 8*b);
         if (fb < 0 && ts[7:0] !== te[7:0]) fb = b;
      end
      if (fb < 0) fb = 0;
      ts = obs >> (1080 - 8*fb);
      te = exp >> (1080 - 8*fb);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s byte %0d observed=%02h expected=%02h", tag, fb, ts[7:0], te[7:0]);
      end
   endtask

   // Behavioural SHA3 core: records blocks, pulses hash_next after more=1, returns a random digest after more=0.
   initial begin
      bus.core_hash_next = 1'b0;
      bus.core_out_valid = 1'b0;
      bus.core_out       = '0;
      rsp_mode = 0;
      rsp_cnt  = 0;
      forever begin
         @(posedge clk); #1;
         bus.core_hash_next = 1'b0;
         bus.core_out_valid = 1'b0;
         if (rst) begin
            rsp_mode = 0;
            rsp_cnt  = 0;
         end else if (bus.core_in_valid) begin
            got_blk.push_back(bus.core_in);
            got_more.push_back(bus.core_more);
            got_cyc.push_back(cyc);
            if (bus.s_ready) sready_bad++;
            rsp_mode = bus.core_more ? 1 : 2;
            rsp_cnt  = $urandom_range(1, 6);
         end else if (rsp_mode != 0) begin
            if (rsp_mode == 1 && bus.s_ready) sready_bad++;
            if (!(rsp_mode == 1 && hold_next)) rsp_cnt--;
            if (rsp_cnt == 0) begin
               if (rsp_mode == 1) begin
                  bus.core_hash_next = 1'b1;
               end else begin
                  for (int i = 0; i < 8; i++) exp_dig[32*i +: 32] = $urandom;
                  bus.core_out       = exp_dig;
                  bus.core_out_valid = 1'b1;
                  ov_cyc             = cyc;
               end
               rsp_mode = 0;
            end
         end
      end
   end

   task automatic send_word(input logic [63:0] w, input bit last, input logic [3:0] nb,
                            input bit toggle, output bit ok, output int t_hs);
      int tw;
      if (toggle) begin
         repeat ($urandom_range(0, 3)) begin
            bus.s_valid = 1'b0;
            @(posedge clk); #1;
         end
      end
      bus.s_valid = 1'b1;
      bus.s_data  = w;
      bus.s_last  = last;
      bus.s_bytes = nb;
      tw = 0;
      while (!bus.s_ready && tw < 3000) begin
         @(posedge clk); #1;
         tw++;
      end
      ok = (tw < 3000);
      if (!ok) chk("word_accept_timeout", tw, 0);
      t_hs = cyc;
      @(posedge clk); #1;
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
   endtask

   task automatic run_msg(input int len, input bit abc, input bit clamp, input int hold, input bit toggle);
      logic [7:0]    msg[$];
      logic [7:0]    pad[$];
      logic [63:0]   w;
      logic [3:0]    nbytes;
      logic [1087:0] eb;
      logic [255:0]  dg;
      int            n, nb, t_hs, t_dummy, tw, idx, j0;
      bit            ok, stable;
      got_blk.delete();
      got_more.delete();
      got_cyc.delete();
      sready_bad = 0;
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
      if (abc) msg = '{8'h61, 8'h62, 8'h63};
      n = (len == 0) ? 1 : (len + 7) / 8;
      t_hs = 0;
      for (int i = 0; i < n; i++) begin
         for (int j = 0; j < 8; j++) begin
            idx = 8*i + j;
            w[63-8*j -: 8] = (idx < len) ? msg[idx] : 8'($urandom);
         end
         nbytes = 4'(len - 8*(n-1));
         if (clamp && nbytes == 4'd8) nbytes = 4'($urandom_range(9, 15));
         send_word(w, (i == n-1), nbytes, toggle, ok, t_dummy);
         if (!ok) return;
         if (i == n-1) t_hs = t_dummy;
      end

      // SHA3 pad10*1 with domain byte 0x06 over the message bytes.
      pad = msg;
      pad.push_back(8'h06);
      while (pad.size() % 136 != 0) pad.push_back(8'h00);
      pad[pad.size()-1] = pad[pad.size()-1] | 8'h80;
      nb = pad.size() / 136;

      tw = 0;
      while (!bus.m_valid && tw < 3000) begin
         @(posedge clk); #1;
         tw++;
      end
      chk("m_valid_seen", bus.m_valid, 1'b1);
      if (!bus.m_valid) return;
      chk("m_valid_latency", cyc, ov_cyc + 1);
      chk("block_count", got_blk.size(), nb);
      for (int i = 0; i < nb && i < got_blk.size(); i++) begin
         for (int b = 0; b < 136; b++) eb[1087-8*b -: 8] = pad[136*i + b];
         chk_blk($sformatf("block%0d_len%0d", i, len), got_blk[i], eb);
         chk($sformatf("more%0d_len%0d", i, len), got_more[i], (i < nb-1));
      end
      j0 = -1;
      for (int i = 0; i < got_cyc.size(); i++) if (j0 < 0 && got_cyc[i] > t_hs) j0 = i;
      chk("last_to_issue_latency", (j0 < 0) ? -1 : got_cyc[j0], t_hs + 2);
      chk("digest", bus.m_digest, exp_dig);
      chk("s_ready_low_while_waiting", sready_bad, 0);

      dg = bus.m_digest;
      stable = 1'b1;
      repeat (hold) begin
         @(posedge clk); #1;
         if (bus.m_digest !== dg || bus.m_valid !== 1'b1 || bus.s_ready !== 1'b0) stable = 1'b0;
      end
      chk("digest_hold_stable", stable, 1'b1);
      bus.m_ready = 1'b1;
      @(posedge clk); #1;
      bus.m_ready = 1'b0;
      chk("m_valid_drop", bus.m_valid, 1'b0);
      chk("ready_after_out", bus.s_ready, 1'b1);
      chk("busy_after_out", bus.busy, 1'b0);
      blk_since  += got_blk.size();
      msgs_since += 1;
`ifdef SHA3_SEQ_STATS_EN
      chk("blk_count", blk_count, blk_since);
      chk("msg_count", msg_count, msgs_since);
`endif
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_core_in_valid"}, bus.core_in_valid, 1'b0);
      chk({tag, "_core_more"}, bus.core_more, 1'b0);
      chk({tag, "_core_in_low"}, bus.core_in[255:0], 256'd0);
      chk({tag, "_core_in_high"}, bus.core_in[1087:832], 256'd0);
      chk({tag, "_m_valid"}, bus.m_valid, 1'b0);
      chk({tag, "_m_digest"}, bus.m_digest, 256'd0);
      chk({tag, "_busy"}, bus.busy, 1'b0);
      chk({tag, "_s_ready"}, bus.s_ready, 1'b0);
   endtask

   initial begin
      bit ok;
      int t_dummy;
      logic [63:0] w;
      rst         = 1'b1;
      hold_next   = 1'b0;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.s_last  = 1'b0;
      bus.s_bytes = 4'd0;
      bus.m_ready = 1'b0;
      blk_since   = 0;
      msgs_since  = 0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      rst = 1'b0;
      @(posedge clk); #1;
      chk("ready_after_reset", bus.s_ready, 1'b1);

      run_msg(0,   1'b0, 1'b0, 0,  1'b0);
      run_msg(3,   1'b1, 1'b0, 0,  1'b0);
      run_msg(135, 1'b0, 1'b0, 0,  1'b0);
      run_msg(136, 1'b0, 1'b1, 0,  1'b0);
      run_msg(200, 1'b0, 1'b0, 10, 1'b1);
      for (int i = 0; i < 4; i++)
         run_msg($urandom_range(0, 420), 1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 4), 1'b1);

      // Abort a message parked in WAIT_NEXT.
      hold_next = 1'b1;
      for (int i = 0; i < 17; i++) begin
         w = {$urandom, $urandom};
         send_word(w, 1'b0, 4'd8, 1'b0, ok, t_dummy);
      end
      repeat (4) @(posedge clk);
      #1;
      chk("wait_next_s_ready", bus.s_ready, 1'b0);
      chk("wait_next_busy", bus.busy, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk_reset_outputs("abort");
      rst       = 1'b0;
      hold_next = 1'b0;
      blk_since  = 0;
      msgs_since = 0;
      @(posedge clk); #1;
      chk("ready_after_abort", bus.s_ready, 1'b1);
`ifdef SHA3_SEQ_STATS_EN
      chk("blk_count_after_abort", blk_count, 16'd0);
`endif
      run_msg(272, 1'b0, 1'b0, 2, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #4000000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end
endmodule
